array_div_stream: RTL

- Multi-lane fixed-point divider. Computes result[i] = (dataa[i] << FRAC) / datab[i] for N lanes in lockstep.
- Uses an iterative radix-2 restoring algorithm: one quotient bit per cycle, one shared FSM and counter, N lane datapaths.
- Successor to the combinational lane-array divider in the inverse (matrix-inversion) pipeline.
- Adds over it: generalised width, lane count and fraction, signed/unsigned mode, valid/ready handshakes, saturation, and per-lane divide-by-zero and overflow flags.

---
 rtl/array_div_pkg.sv | 35 +++
 rtl/array_div_if.sv | 26 ++
 rtl/array_div_lane.sv | 108 ++++++++++
 rtl/array_div_stream.sv | 104 ++++++++++
 4 files changed

// File: rtl/array_div_pkg.sv
// array_div_stream shared types and constants.
// Widths, FSM states and saturation helpers.
package array_div_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam int N_DEF      = 15;
   localparam int W_DEF      = 27;
   localparam int FRAC_DEF   = 16;
   localparam int SIGNED_DEF = 0;

   localparam int Q     = W_DEF + FRAC_DEF;
   localparam int REM_W = W_DEF + 1;

   function automatic int q_w(input int w, input int frac);
      return w + frac;
   endfunction

   function automatic int rem_w(input int w);
      return w + 1;
   endfunction

   function automatic logic [63:0] max_pos(input int w, input int sgn);
      logic [63:0] one;
      one = 64'd1;
      return (sgn != 0) ? (one << (w - 1)) - one : (one << w) - one;
   endfunction

   function automatic logic [63:0] min_neg(input int w);
      logic [63:0] one;
      one = 64'd1;
      return one << (w - 1);
   endfunction

endpackage

// File: rtl/array_div_if.sv
// Operand/result handshake bundle for array_div_stream.
// master = producer/consumer side, slave = divider.
interface array_div_if #(
   parameter int N = array_div_pkg::N_DEF,
   parameter int W = array_div_pkg::W_DEF
) ();
   logic                  in_valid;
   logic                  in_ready;
   logic [N-1:0][W-1:0]   dataa;
   logic [N-1:0][W-1:0]   datab;
   logic                  out_valid;
   logic                  out_ready;
   logic [N-1:0][W-1:0]   result;
   logic [N-1:0]          div_by_zero;
   logic [N-1:0]          overflow;

   modport master (
      output in_valid, dataa, datab, out_ready,
      input  in_ready, out_valid, result, div_by_zero, overflow
   );

   modport slave (
      input  in_valid, dataa, datab, out_ready,
      output in_ready, out_valid, result, div_by_zero, overflow
   );
endinterface

// File: rtl/array_div_lane.sv
// One lane of the restoring divider: capture, shift/subtract,
// and final sign / saturation / divide-by-zero handling.
module array_div_lane
   import array_div_pkg::*;
#(
   parameter int W      = W_DEF,
   parameter int FRAC   = FRAC_DEF,
   parameter int SIGNED = SIGNED_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         step,
   input  logic         finish,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] result,
   output logic         dz,
   output logic         ov
);
   localparam int LQ  = q_w(W, FRAC);
   localparam int LRW = rem_w(W);

   localparam logic [63:0]   MAXP64 = max_pos(W, SIGNED);
   localparam logic [63:0]   MINN64 = min_neg(W);
   localparam logic [W-1:0]  MAXP   = MAXP64[W-1:0];
   localparam logic [W-1:0]  MINN   = MINN64[W-1:0];
   localparam logic [LQ-1:0] LIM_P  = LQ'(MAXP);
   localparam logic [LQ-1:0] LIM_N  = LQ'(MINN);

   logic [W-1:0]   mb;
   logic [W-1:0]   rem;
   logic [LQ-1:0]  qd;
   logic           sa, sb, bz;

   logic           a_neg, b_neg;
   logic [W-1:0]   amag, bmag;
   logic [LRW-1:0] rem_sh;
   logic           ge;
   logic [W-1:0]   rem_n;
   logic [LQ-1:0]  qd_n;
   logic [W-1:0]   res_c;
   logic           ov_c;

   // Operand magnitudes and one shift/subtract step.
   always_comb begin
      a_neg  = (SIGNED != 0) && a[W-1];
      b_neg  = (SIGNED != 0) && b[W-1];
      amag   = a_neg ? -a : a;
      bmag   = b_neg ? -b : b;
      rem_sh = {rem, qd[LQ-1]};
      ge     = rem_sh >= {1'b0, mb};
      rem_n  = ge ? W'(rem_sh - {1'b0, mb}) : rem_sh[W-1:0];
      qd_n   = {qd[LQ-2:0], ge};
   end

   // Sign, saturation and zero-divisor result from the final quotient.
   always_comb begin
      res_c = qd_n[W-1:0];
      ov_c  = 1'b0;
      if (bz) begin
         res_c = sa ? MINN : MAXP;
      end else if (sa ^ sb) begin
         if (qd_n > LIM_N) begin
            res_c = MINN;
            ov_c  = 1'b1;
         end else begin
            res_c = -qd_n[W-1:0];
         end
      end else if (qd_n > LIM_P) begin
         res_c = MAXP;
         ov_c  = 1'b1;
      end
   end

   // Dividend bits shift out of qd while quotient bits shift in.
   always_ff @(posedge clk) begin
      if (rst) begin
         mb     <= '0;
         rem    <= '0;
         qd     <= '0;
         sa     <= 1'b0;
         sb     <= 1'b0;
         bz     <= 1'b0;
         result <= '0;
         dz     <= 1'b0;
         ov     <= 1'b0;
      end else begin
         if (load) begin
            mb  <= bmag;
            rem <= '0;
            qd  <= LQ'(amag) << FRAC;
            sa  <= a_neg;
            sb  <= b_neg;
            bz  <= (b == '0);
         end else if (step) begin
            rem <= rem_n;
            qd  <= qd_n;
         end
         if (finish) begin
            result <= res_c;
            dz     <= bz;
            ov     <= ov_c;
         end
      end
   end

endmodule

// File: rtl/array_div_stream.sv
// N-lane iterative fixed-point divider with valid/ready handshakes.
// Shared FSM and bit counter drive lockstep lane datapaths.
module array_div_stream
   import array_div_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int W      = W_DEF,
   parameter int FRAC   = FRAC_DEF,
   parameter int SIGNED = SIGNED_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   array_div_if.slave  bus
);
   localparam int LQ = q_w(W, FRAC);
   localparam int CW = (LQ > 1) ? $clog2(LQ) : 1;

   state_t        state, nstate;
   logic [CW-1:0] cnt;
   logic          load, step, fin, rdy;

   // Next state and per-cycle lane strobes.
   always_comb begin
      nstate = state;
      rdy    = 1'b0;
      load   = 1'b0;
      step   = 1'b0;
      fin    = 1'b0;
      unique case (state)
         IDLE: begin
            rdy = 1'b1;
            if (en && bus.in_valid) begin
               load   = 1'b1;
               nstate = BUSY;
            end
         end
         BUSY: begin
            step = en;
            if (en && cnt == '0) begin
               fin    = 1'b1;
               nstate = DONE;
            end
         end
         DONE: begin
            rdy = bus.out_ready;
            if (en && bus.out_ready) begin
               if (bus.in_valid) begin
                  load   = 1'b1;
                  nstate = BUSY;
               end else begin
                  nstate = IDLE;
               end
            end
         end
         default: nstate = IDLE;
      endcase
   end

   // State register and iteration counter; frozen while en is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (en) begin
         state <= nstate;
         if (load) begin
            cnt <= CW'(LQ - 1);
         end else if (step && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.out_valid = (state == DONE);

   logic [N-1:0][W-1:0] res;
   logic [N-1:0]        dzv, ovv;

   for (genvar i = 0; i < N; i++) begin : g_lane
      array_div_lane #(
         .W      (W),
         .FRAC   (FRAC),
         .SIGNED (SIGNED)
      ) u_lane (
         .clk    (clk),
         .rst    (rst),
         .load   (load),
         .step   (step),
         .finish (fin),
         .a      (bus.dataa[i]),
         .b      (bus.datab[i]),
         .result (res[i]),
         .dz     (dzv[i]),
         .ov     (ovv[i])
      );
   end

   assign bus.result      = res;
   assign bus.div_by_zero = dzv;
   assign bus.overflow    = ovv;

endmodule
